// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: takes one 16-bit sample per valid/ready handshake and
// shifts it MSB-first to an external DAC over sclk / sync_n / sdo.
// sclk idles high; sdo moves only when sclk rises, so it is stable at the
// falling edge where the DAC samples. sync_n stays high for at least
// GAP_CYCLES cycles between frames.
module dac_spi_serializer #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  ready,
    output logic                  done,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  sclk,
    output logic                  sync_n,
    output logic                  sdo
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST = 5'(DATA_WIDTH - 1);
    localparam logic [4:0]       BIT_SAT  = 5'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                state, state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  phase;      // 0: sclk high half, 1: sclk low half
    logic [4:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    logic accept;
    logic div_end;

    assign accept  = (state == IDLE) && data_valid;
    assign div_end = (div_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a frame ends at the close of the low half of the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (div_end && phase && bit_cnt == BIT_LAST) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from state and the half-period phase.
    always_comb begin
        ready  = (state == IDLE);
        sync_n = (state != SHIFT);
        sclk   = (state != SHIFT) || !phase;
        sdo    = (state == SHIFT) && shreg[DATA_WIDTH-1];
        done   = (state == GAP) && (gap_cnt == '0);
    end

    // Datapath: divider, bit counter, gap counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    gap_cnt <= '0;
                    if (accept) begin
                        shreg   <= data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        phase   <= !phase;
                        // Advancing at the end of the low half makes the new
                        // bit appear together with the sclk rising edge.
                        if (phase) begin
                            shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
                end
                default: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky overrun: a valid that cannot be accepted is dropped and flagged;
    // a simultaneous clear loses to the set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   overrun <= 1'b0;
        else if (data_valid && !ready) overrun <= 1'b1;
        else if (overrun_clr)          overrun <= 1'b0;
    end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: three instances (CLK_DIV/GAP = 2/4, 1/1,
// 255/4), a per-cycle arithmetic reference model for every instance, a
// table of handshake/overrun vectors and hand-written frame sequences.
module tb_dac_spi_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv  [3];
    logic        clr [3];
    logic [15:0] dat [3];
    logic        rdy [3];
    logic        dn  [3];
    logic        ovr [3];
    logic        sck [3];
    logic        syn [3];
    logic        sdo [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dac_spi_serializer #(.CLK_DIV(2), .DATA_WIDTH(16), .GAP_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .data(dat[0]), .data_valid(dv[0]), .ready(rdy[0]),
        .done(dn[0]), .overrun(ovr[0]), .overrun_clr(clr[0]), .sclk(sck[0]),
        .sync_n(syn[0]), .sdo(sdo[0]));
    dac_spi_serializer #(.CLK_DIV(1), .DATA_WIDTH(16), .GAP_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .data(dat[1]), .data_valid(dv[1]), .ready(rdy[1]),
        .done(dn[1]), .overrun(ovr[1]), .overrun_clr(clr[1]), .sclk(sck[1]),
        .sync_n(syn[1]), .sdo(sdo[1]));
    dac_spi_serializer #(.CLK_DIV(255), .DATA_WIDTH(16), .GAP_CYCLES(4)) u_c (
        .clk(clk), .rst_n(rst_n), .data(dat[2]), .data_valid(dv[2]), .ready(rdy[2]),
        .done(dn[2]), .overrun(ovr[2]), .overrun_clr(clr[2]), .sclk(sck[2]),
        .sync_n(syn[2]), .sdo(sdo[2]));

    function automatic int div_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    function automatic int gap_of(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: t = cycles since the accepting edge. Frame occupies
    // t < 32*D, done at t == 32*D, gap until t == 32*D+G, then idle/ready.
    typedef struct {
        bit          active;
        int          t;
        logic [15:0] word;
        bit          ov;
    } model_t;

    model_t m [3];

    // Expected {ready, done, overrun, sclk, sync_n, sdo} for the current cycle.
    function automatic logic [5:0] mexp(input model_t s, input int d, input logic r);
        logic ck, bt;
        if (!r)        return 6'b100110;
        if (!s.active) return {1'b1, 1'b0, s.ov, 1'b1, 1'b1, 1'b0};
        if (s.t < 32 * d) begin
            ck = ((s.t % (2 * d)) < d);
            bt = s.word[15 - s.t / (2 * d)];
            return {1'b0, 1'b0, s.ov, ck, 1'b0, bt};
        end
        return {1'b0, (s.t == 32 * d), s.ov, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic model_t mnext(input model_t s, input int d, input int g,
                                     input logic v, input logic c, input logic [15:0] x);
        model_t n = s;
        if (v && s.active)  n.ov = 1'b1;
        else if (c)         n.ov = 1'b0;
        if (s.active) begin
            n.t = s.t + 1;
            if (n.t == 32 * d + g) n.active = 1'b0;
        end else if (v) begin
            n.active = 1'b1;
            n.t      = 0;
            n.word   = x;
        end
        return n;
    endfunction

    // Every cycle, compare all outputs of every instance with the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cycle_dut%0d", k),
                {rdy[k], dn[k], ovr[k], sck[k], syn[k], sdo[k]},
                mexp(m[k], div_of(k), rst_n));
            if (!rst_n) begin
                m[k].active = 1'b0;
                m[k].t      = 0;
                m[k].ov     = 1'b0;
            end else begin
                m[k] = mnext(m[k], div_of(k), gap_of(k), dv[k], clr[k], dat[k]);
            end
        end
    end

    // One frame on instance k: checks length, captured bits, done, gap,
    // sclk period and (optionally with data churning) sdo stability.
    task automatic frame(input int k, input logic [15:0] d, input bit wiggle, input bit pre);
        int low, ndone, done_at, rdy_at, f1, f2, d2, g;
        logic [15:0] cap;
        logic ps, psdo;
        bit bad;
        d2 = div_of(k);
        g  = gap_of(k);
        if (!pre) begin
            @(posedge clk); #1;
        end
        dv[k] = 1'b1; dat[k] = d;
        @(posedge clk); #1;
        dv[k] = 1'b0;
        low = 0; ndone = 0; done_at = -1; rdy_at = -1; f1 = -1; f2 = -1;
        cap = '0; ps = 1'b1; psdo = 1'b0; bad = 1'b0;
        for (int cyc = 0; cyc < 20000 && rdy_at < 0; cyc++) begin
            if (wiggle) dat[k] = 16'($urandom);
            @(negedge clk);
            if (!syn[k]) low++;
            if (!syn[k] && ps && !sck[k]) begin
                cap = {cap[14:0], sdo[k]};
                if (f1 < 0) f1 = cyc;
                else if (f2 < 0) f2 = cyc;
            end
            if (!syn[k] && !sck[k] && sdo[k] !== psdo) bad = 1'b1;
            if (dn[k]) begin ndone++; done_at = cyc; end
            if (rdy[k]) rdy_at = cyc;
            ps = sck[k]; psdo = sdo[k];
            @(posedge clk); #1;
        end
        chk($sformatf("dut%0d_ready_timeout", k), (rdy_at >= 0), 1);
        chk($sformatf("dut%0d_sync_low_len", k), low, 32 * d2);
        chk($sformatf("dut%0d_bits", k), cap, d);
        chk($sformatf("dut%0d_done_count", k), ndone, 1);
        chk($sformatf("dut%0d_done_at", k), done_at, 32 * d2);
        chk($sformatf("dut%0d_done_to_ready", k), rdy_at - done_at, g);
        chk($sformatf("dut%0d_sclk_period", k), f2 - f1, 2 * d2);
        chk($sformatf("dut%0d_sdo_stable", k), bad, 0);
    endtask

    typedef struct {
        logic        v;
        logic        c;
        logic [15:0] x;
        logic        e_rdy;
        logic        e_ovr;
    } vec_t;

    initial begin
        vec_t tbl [9];
        logic ps;
        int nf;
        int falls [3];

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0; clr[k] = 1'b0; dat[k] = '0;
            m[k].active = 1'b0; m[k].t = 0; m[k].word = '0; m[k].ov = 1'b0;
        end
        // Handshake / overrun vectors for instance 0 (outputs seen before
        // the edge that consumes the row's inputs).
        tbl[0] = '{1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single frame, CLK_DIV=2, GAP=4.
        frame(0, 16'hA5C3, 1'b0, 1'b0);

        // Overrun / clear table; frame content is covered by the model.
        for (int i = 0; i < 9; i++) begin
            dv[0] = tbl[i].v; clr[0] = tbl[i].c; dat[0] = tbl[i].x;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), rdy[0], tbl[i].e_rdy);
            chk($sformatf("tbl%0d_overrun", i), ovr[0], tbl[i].e_ovr);
            @(posedge clk); #1;
        end
        dv[0] = 1'b0; clr[0] = 1'b0;
        repeat (80) @(posedge clk);
        #1;

        // Data churning during a frame.
        frame(0, 16'h5A5A, 1'b1, 1'b0);

        // Reset at the start of bit 7 of 0x8001.
        dv[0] = 1'b1; dat[0] = 16'h8001;
        @(posedge clk); #1 dv[0] = 1'b0;
        repeat (28) @(posedge clk);
        #1;
        chk("rst_pre_sync", syn[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_sync", syn[0], 1'b1);
        chk("rst_sclk", sck[0], 1'b1);
        chk("rst_sdo", sdo[0], 1'b0);
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_done", dn[0], 1'b0);
        dv[0] = 1'b1; dat[0] = 16'h00FF;
        @(posedge clk); #1 rst_n = 1'b1;
        frame(0, 16'h00FF, 1'b0, 1'b1);

        // Back-to-back with valid held high, CLK_DIV=1, GAP=1.
        dv[1] = 1'b1; dat[1] = 16'h0000;
        ps = 1'b1; nf = 0;
        for (int i = 0; i < 75; i++) begin
            @(negedge clk);
            if (ps && !syn[1] && nf < 3) begin falls[nf] = i; nf++; end
            if (i == 1) chk("b2b_ovr_first", ovr[1], 1'b0);
            if (i == 2) chk("b2b_ovr_second", ovr[1], 1'b1);
            ps = syn[1];
            @(posedge clk); #1;
            dat[1] = ((((i + 1) / 34) % 2) == 1) ? 16'hFFFF : 16'h0000;
        end
        chk("b2b_accepts", nf, 3);
        chk("b2b_spacing1", falls[1] - falls[0], 34);
        chk("b2b_spacing2", falls[2] - falls[1], 34);
        clr[1] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_set_wins", ovr[1], 1'b1);
        dv[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_clr", ovr[1], 1'b0);
        clr[1] = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // CLK_DIV=255 boundary.
        frame(2, 16'h8000, 1'b0, 1'b0);

        // Random traffic on the two fast instances against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                dv[k]  = ($urandom % 4) == 0;
                clr[k] = ($urandom % 16) == 0;
                dat[k] = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin dv[k] = 1'b0; clr[k] = 1'b0; end
        repeat (100) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
